// File: rtl/decode_cycle.sv
// Decode stage: RV32I-subset decoder, 32x32 register file with write-through
// bypass, immediate extension and the ID/EX pipeline register.
module decode_cycle #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 9,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic [PC_WIDTH-1:0]   PCD,
  input  logic [PC_WIDTH-1:0]   PCPlus4D,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  FlushE,
  output logic [REG_ADDR_W-1:0] Rs1D,
  output logic [REG_ADDR_W-1:0] Rs2D,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [PC_WIDTH-1:0]   PCE,
  output logic [PC_WIDTH-1:0]   PCPlus4E,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            ALUControlE,
  output logic                  IllegalE
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pcp4;
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [2:0]            alu_control;
    logic                  illegal;
  } idex_t;

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [2:0]            alu_f3;
  logic                  f3_ok;
  logic                  wr_en;
  idex_t                 idex_d, idex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[15 +: REG_ADDR_W];
  assign Rs2D   = InstrD[20 +: REG_ADDR_W];
  assign wr_en  = RegWriteW && (RdW != '0);

  // Register file; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[RdW] <= ResultW;
    end
  end

  // Same-cycle writeback is forwarded so the reader never sees stale data
  assign rd1 = (Rs1D == '0) ? '0 : ((wr_en && RdW == Rs1D) ? ResultW : rf[Rs1D]);
  assign rd2 = (Rs2D == '0) ? '0 : ((wr_en && RdW == Rs2D) ? ResultW : rf[Rs2D]);

  assign imm_i = {{(DATA_WIDTH-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){InstrD[31]}}, InstrD[31], InstrD[7],
                  InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_j = {{(DATA_WIDTH-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                  InstrD[20], InstrD[30:21], 1'b0};

  // funct3 -> ALU op for R/I types; funct7[5] selects sub only for R-type
  always_comb begin
    alu_f3 = ALU_ADD;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_f3 = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_f3 = ALU_SLT;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    idex_d      = '0;
    idex_d.rd1  = rd1;
    idex_d.rd2  = rd2;
    idex_d.rs1  = Rs1D;
    idex_d.rs2  = Rs2D;
    idex_d.rd   = InstrD[7 +: REG_ADDR_W];
    idex_d.pc   = PCD;
    idex_d.pcp4 = PCPlus4D;
    case (opcode)
      OP_R: begin
        idex_d.reg_write   = 1'b1;
        idex_d.alu_control = alu_f3;
        idex_d.illegal     = ~f3_ok;
      end
      OP_I: begin
        idex_d.reg_write   = 1'b1;
        idex_d.alu_src     = 1'b1;
        idex_d.imm         = imm_i;
        idex_d.alu_control = alu_f3;
        idex_d.illegal     = ~f3_ok;
      end
      OP_LOAD: begin
        idex_d.reg_write  = 1'b1;
        idex_d.alu_src    = 1'b1;
        idex_d.result_src = RES_MEM;
        idex_d.imm        = imm_i;
      end
      OP_STORE: begin
        idex_d.mem_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.imm       = imm_s;
      end
      OP_BR: begin
        idex_d.branch      = 1'b1;
        idex_d.alu_control = ALU_SUB;
        idex_d.imm         = imm_b;
      end
      OP_JAL: begin
        idex_d.reg_write  = 1'b1;
        idex_d.jump       = 1'b1;
        idex_d.result_src = RES_PC4;
        idex_d.imm        = imm_j;
      end
      default: idex_d.illegal = 1'b1;
    endcase
    if (idex_d.result_src == RES_ALU && idex_d.alu_control == ALU_AND && !f3_ok) begin
      idex_d.alu_control = ALU_ADD;
    end
  end

  // ID/EX register: loads every cycle, flush inserts an all-zero bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else if (FlushE) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pcp4;
  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_control;
  assign IllegalE    = idex_q.illegal;

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Decode stage of the 5-stage pipeline. It sits directly downstream of fetch_cycle and consumes its registered IF/ID outputs (InstrD, PCD, PCPlus4D). It decodes an RV32I subset, reads the internal 32x32 register file (written by writeback), sign-extends immediates, and registers everything into the ID/EX pipeline register feeding execute.

Parameters:
DATA_WIDTH, 32, register/immediate/data width
PC_WIDTH, 9, PC width; matches fetch_cycle
REG_ADDR_W, 5, register index width (32 registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
InstrD  in  32  instruction from fetch_cycle
PCD  in  PC_WIDTH  PC of InstrD
PCPlus4D  in  PC_WIDTH  PCD+4
RegWriteW  in  1  writeback enable
RdW  in  REG_ADDR_W  writeback destination
ResultW  in  DATA_WIDTH  writeback data
FlushE  in  1  hazard unit: load bubble into ID/EX
Rs1D  out  REG_ADDR_W  InstrD[19:15], combinational, for hazard unit
Rs2D  out  REG_ADDR_W  InstrD[24:20], combinational
RD1E, RD2E  out  DATA_WIDTH  registered operand values
ImmExtE  out  DATA_WIDTH  registered sign-extended immediate
Rs1E, Rs2E, RdE  out  REG_ADDR_W  registered register indices
PCE, PCPlus4E  out  PC_WIDTH  registered PC values
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1  registered controls
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
IllegalE  out  1  registered unknown-opcode flag

Behaviour:
- Reset (async, rst=1): every *E output goes to 0 immediately. All 32 registers clear to 0. Rs1D/Rs2D stay combinational.
- Latency: one cycle. InstrD decoded in cycle N appears on *E outputs after the rising edge ending cycle N.
- ID/EX register has no stall input. It loads every cycle. Hold of an instruction is handled by StallD/StallF in fetch_cycle.
- FlushE=1 at an edge: all controls (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE) load 0. Data/index fields also load 0. FlushE has priority over normal load.
- Register file writes on the rising edge when RegWriteW=1 and RdW!=0. Writes to x0 are ignored and x0 always reads 0.
- Write-through bypass: in the same cycle that RegWriteW=1, RdW!=0 and RdW equals rs1/rs2, the read returns ResultW. This avoids a half-cycle write.
- Decode by opcode (InstrD[6:0]):
  - 0110011 R-type: RegWrite=1, ALUSrc=0, ResultSrc=00, imm don't-care (0). ALUControl from funct3; funct3=000 with funct7[5]=1 gives sub.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, I-imm. funct3 000 add, 010 slt, 110 or, 111 and. funct7[5] is ignored.
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=01, add, I-imm.
  - 0100011 sw: MemWrite=1, ALUSrc=1, add, S-imm.
  - 1100011 beq: Branch=1, sub, B-imm.
  - 1101111 jal: RegWrite=1, Jump=1, ResultSrc=10, J-imm.
  - Any other opcode: all controls 0, IllegalE=1.
  - Unsupported funct3 in R/I types: ALUControl=000 and IllegalE=1, with other controls kept.
- Immediates, sign-extended from InstrD[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
- A write and a flush in the same cycle are independent: the register file still writes.
- If reset deasserts mid-stream, the first edge after deassertion loads the current InstrD normally.

Test Plan:
- Assert rst asynchronously mid-cycle while ID/EX holds a jal -> all *E outputs read 0 before the next edge; x5 then reads 0.
- Write x5=0x000000AA (RegWriteW=1, RdW=5), next cycle InstrD=0x000280B3 (add x1,x5,x0) -> after edge RD1E=0x000000AA, RD2E=0, RdE=1, RegWriteE=1, ALUControlE=000, ALUSrcE=0.
- Same cycle RegWriteW=1, RdW=5, ResultW=0x00001234 with InstrD=0x000280B3 -> RD1E=0x00001234 (bypass).
- RegWriteW=1, RdW=0, ResultW=0xFFFFFFFF, then decode 0x000000B3 (add x1,x0,x0) -> RD1E=0, RD2E=0.
- InstrD=0xFE208CE3 (beq x1,x2,-8), PCD=0x010 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, PCE=0x010, RegWriteE=0.
- InstrD=lw 0x0040A183 with FlushE=1 -> all controls 0. Next cycle with FlushE=0 -> ResultSrcE=01, ImmExtE=4, RdE=3. Then InstrD=0x0000007F -> IllegalE=1, all other controls 0.
